// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer / UART-side bundle of the shared transmitter arbiter.
// master = arbiter view, slave = requesters plus UART view.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Busy;
  logic                 o_Timeout;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;

  modport master (
    input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    output o_Grant, o_Busy, o_Timeout, o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Grant, o_Busy, o_Timeout, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that pulses o_Timeout on expiry.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 32'd300000
) (
  input  logic              CLK_25MHZ,
  input  logic              RSTN,
  uart_tx_arbiter_if.master bus_io
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {StIdle, StWaitDone, StGap} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                dv_q, dv_d;
  logic [7:0]          byte_q, byte_d;
  logic [GapW-1:0]     gap_q, gap_d;

  logic                win_valid;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW-1:0]     win_next;
  logic [7:0]          win_byte;
  int unsigned         cand;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]         wd_q, wd_d;
  logic                tmo_q, tmo_d;
`endif

  // Search upward from the rr pointer, wrapping, for the first pending request.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_valid && bus_io.i_Req[PtrW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = PtrW'(cand);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PtrW'(i) == win_idx) begin
        win_byte = bus_io.i_Req_Byte[8*i +: 8];
      end
    end
    win_next = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    gap_d   = '0;
`ifdef UART_ARB_TIMEOUT_EN
    wd_d    = '0;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // A frame still shifting (ours or someone else's) blocks the launch.
        if (win_valid && !bus_io.i_Tx_Active) begin
          grant_d = NUM_REQ'(1) << win_idx;
          dv_d    = 1'b1;
          byte_d  = win_byte;
          ptr_d   = win_next;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus_io.i_Tx_Done) begin
          state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (wd_q == TIMEOUT_CYCLES - 1) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 32'd1;
`endif
        end
      end
      StGap: begin
        if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RSTN) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge CLK_25MHZ) begin
    if (RSTN) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus_io.o_Timeout = tmo_q;
`else
  assign bus_io.o_Timeout = 1'b0;
`endif

  assign bus_io.o_Grant   = grant_q;
  assign bus_io.o_Tx_DV   = dv_q;
  assign bus_io.o_Tx_Byte = byte_q;
  assign bus_io.o_Busy    = (state_q != StIdle);

endmodule
